// File: rtl/phy_rdata_buf.sv
// Read-beat buffer between the NAND PHY read sequencer and the DMA AXI-Stream sink.
// Optional per-packet beat counter: define RDBUF_PKT_BEATCNT_EN to add o_pkt_beats / o_pkt_done.
module phy_rdata_buf #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 64,
  parameter int RREADY_MARGIN = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_rvalid,
  input  logic [DATA_WIDTH-1:0]  i_rdata,
  input  logic [15:0]            i_rid,
  input  logic [15:0]            i_ruser,
  input  logic                   i_rlast,
  output logic                   o_rready,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [15:0]            m_axis_tid,
  output logic [15:0]            m_axis_tuser,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow,
  output logic                   o_orphan_last,
`ifdef RDBUF_PKT_BEATCNT_EN
  output logic [15:0]            o_pkt_beats,
  output logic                   o_pkt_done,
`endif
  input  logic                   i_clr_err
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic                  last;
    logic [15:0]           user;
    logic [15:0]           id;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t         stg;
  logic          stg_valid;
  beat_t         mem [DEPTH];
  beat_t         head;
  beat_t         push_beat;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          ovf_set;
  logic          orphan_set;
  int            free_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    full           = level[AW];
    pop            = m_axis_tvalid & m_axis_tready;
    push_req       = stg_valid & (i_rvalid | i_rlast | stg.last);
    push_ok        = push_req & (~full | pop);
    ovf_set        = push_req & ~push_ok;
    orphan_set     = ~i_rvalid & i_rlast & ~stg_valid;
    push_beat      = stg;
    // A bare rlast closes the packet on the beat currently being pushed.
    push_beat.last = stg.last | (i_rlast & ~i_rvalid);
    free_next      = DEPTH - int'(level) - int'(stg_valid) - int'(push_ok) + int'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid <= 1'b0;
      stg       <= '0;
    end else if (i_rvalid) begin
      stg_valid <= 1'b1;
      stg       <= '{last: i_rlast, user: i_ruser, id: i_rid, data: i_rdata};
    end else if (stg_valid & (i_rlast | stg.last)) begin
      stg_valid <= 1'b0;
      stg.last  <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_beat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Space signal looks ahead at this cycle's push/pop; the PHY sees it one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) o_rready <= 1'b0;
    else        o_rready <= (free_next >= RREADY_MARGIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_overflow    <= 1'b0;
      o_orphan_last <= 1'b0;
    end else begin
      o_overflow    <= (o_overflow & ~i_clr_err) | ovf_set;
      o_orphan_last <= (o_orphan_last & ~i_clr_err) | orphan_set;
    end
  end

  // Payload is forced to zero while empty so the unreset array never leaks X.
  always_comb begin
    head          = mem[rd_ptr];
    m_axis_tvalid = (level != '0);
    m_axis_tdata  = m_axis_tvalid ? head.data : '0;
    m_axis_tlast  = m_axis_tvalid ? head.last : 1'b0;
    m_axis_tid    = m_axis_tvalid ? head.id   : '0;
    m_axis_tuser  = m_axis_tvalid ? head.user : '0;
    o_level       = level;
  end

`ifdef RDBUF_PKT_BEATCNT_EN
  logic [15:0] beat_cnt;
  logic [15:0] cnt_inc;

  always_comb begin
    cnt_inc = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      o_pkt_beats <= '0;
      o_pkt_done  <= 1'b0;
    end else begin
      o_pkt_done <= 1'b0;
      if (push_ok) begin
        if (push_beat.last) begin
          o_pkt_beats <= cnt_inc;
          o_pkt_done  <= 1'b1;
          beat_cnt    <= '0;
        end else begin
          beat_cnt <= cnt_inc;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_phy_rdata_buf.sv
// Directed self-checking bench for phy_rdata_buf (default build, DEPTH=64, margin 16).
module tb_phy_rdata_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic [15:0] i_rid;
  logic [15:0] i_ruser;
  logic        i_rlast;
  logic        o_rready;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [15:0] m_axis_tid;
  logic [15:0] m_axis_tuser;
  logic [6:0]  o_level;
  logic        o_overflow;
  logic        o_orphan_last;
  logic        i_clr_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] id;
    logic [15:0] user;
  } obs_t;
  obs_t q[$];

  phy_rdata_buf dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rvalid      (i_rvalid),
    .i_rdata       (i_rdata),
    .i_rid         (i_rid),
    .i_ruser       (i_ruser),
    .i_rlast       (i_rlast),
    .o_rready      (o_rready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tuser  (m_axis_tuser),
    .o_level       (o_level),
    .o_overflow    (o_overflow),
    .o_orphan_last (o_orphan_last),
    .i_clr_err     (i_clr_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so a negedge sample predicts the next-edge pop.
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready)
      q.push_back('{data: m_axis_tdata, last: m_axis_tlast, id: m_axis_tid, user: m_axis_tuser});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [15:0] id, input logic last);
    i_rvalid = 1'b1;
    i_rdata  = d;
    i_rid    = id;
    i_rlast  = last;
    tick();
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
  endtask

  task automatic apply_reset();
    i_rvalid = 1'b0; i_rdata = '0; i_rid = '0; i_ruser = 16'h00A5;
    i_rlast = 1'b0; i_clr_err = 1'b0; m_axis_tready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    q.delete();
  endtask

  task automatic test_reset();
    i_rvalid = 1'b0; i_rdata = '0; i_rid = '0; i_ruser = 16'h00A5;
    i_rlast = 1'b0; i_clr_err = 1'b0; m_axis_tready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (o_rready !== 1'b0) begin n_err++; $display("FAIL rst_rready got %b want 0", o_rready); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
    n_cmp++; if (o_level !== 7'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", o_level); end
    n_cmp++; if ({m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tuser} !== 65'd0) begin n_err++; $display("FAIL rst_payload got %h want 0", {m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tuser}); end
    n_cmp++; if ({o_overflow, o_orphan_last} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b want 00", {o_overflow, o_orphan_last}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (o_rready !== 1'b1) begin n_err++; $display("FAIL rst_release_rready got %b want 1", o_rready); end
  endtask

  task automatic test_basic_packet();
    apply_reset();
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 4; i++) send_beat(32'h11 * i, 16'h0100 + 16'(i), i == 4);
    repeat (4) tick();
    n_cmp++; if (q.size() !== 4) begin n_err++; $display("FAIL t1_count got %0d want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (q[i].data !== 32'h11 * (i + 1) || q[i].last !== (i == 3) || q[i].id !== 16'h0101 + 16'(i) || q[i].user !== 16'h00A5) begin
        n_err++;
        $display("FAIL t1_beat%0d got d=%h l=%b id=%h u=%h want d=%h l=%b id=%h u=00a5", i, q[i].data, q[i].last, q[i].id, q[i].user, 32'h11 * (i + 1), i == 3, 16'h0101 + 16'(i));
      end
    end
    n_cmp++; if (o_level !== 7'd0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL t1_drain got level=%0d tvalid=%b want 0/0", o_level, m_axis_tvalid); end
  endtask

  task automatic test_late_rlast();
    apply_reset();
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 3; i++) send_beat(32'hA0 + i, 16'h0200 + 16'(i), 1'b0);
    repeat (4) tick();
    n_cmp++; if (q.size() !== 2) begin n_err++; $display("FAIL t2_pre_count got %0d want 2", q.size()); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL t2_held got tvalid=%b want 0", m_axis_tvalid); end
    i_rlast = 1'b1;
    tick();
    i_rlast = 1'b0;
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA3 || m_axis_tlast !== 1'b1) begin n_err++; $display("FAIL t2_last_beat got v=%b d=%h l=%b want 1/a3/1", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    repeat (3) tick();
    n_cmp++; if (q.size() !== 3) begin n_err++; $display("FAIL t2_count got %0d want 3", q.size()); end
    n_cmp++; if ({q[0].last, q[1].last, q[2].last} !== 3'b001 || q[0].data !== 32'hA1 || q[1].data !== 32'hA2) begin n_err++; $display("FAIL t2_order got l=%b%b%b d0=%h d1=%h want 001/a1/a2", q[0].last, q[1].last, q[2].last, q[0].data, q[1].data); end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    for (int i = 1; i <= 48; i++) send_beat(32'(i), 16'h0300, 1'b0);
    n_cmp++; if (o_level !== 7'd47 || o_rready !== 1'b1) begin n_err++; $display("FAIL t3_48beats got level=%0d rready=%b want 47/1", o_level, o_rready); end
    send_beat(32'd49, 16'h0300, 1'b0);
    n_cmp++; if (o_level !== 7'd48 || o_rready !== 1'b0) begin n_err++; $display("FAIL t3_rready_drop got level=%0d rready=%b want 48/0", o_level, o_rready); end
    for (int i = 50; i <= 112; i++) send_beat(32'(i), 16'h0300, 1'b0);
    n_cmp++; if (o_level !== 7'd64 || o_overflow !== 1'b1) begin n_err++; $display("FAIL t3_full got level=%0d ovf=%b want 64/1", o_level, o_overflow); end
    n_cmp++; if (m_axis_tdata !== 32'd1 || o_orphan_last !== 1'b0) begin n_err++; $display("FAIL t3_head got d=%0d orphan=%b want 1/0", m_axis_tdata, o_orphan_last); end
    i_clr_err = 1'b1;
    send_beat(32'd113, 16'h0300, 1'b0);
    n_cmp++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL t3_set_wins got ovf=%b want 1", o_overflow); end
    tick();
    i_clr_err = 1'b0;
    n_cmp++; if (o_overflow !== 1'b0 || o_level !== 7'd64) begin n_err++; $display("FAIL t3_clear got ovf=%b level=%0d want 0/64", o_overflow, o_level); end
  endtask

  // Continues from the full FIFO left by test_fill_overflow.
  task automatic test_full_push_pop();
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd1) begin n_err++; $display("FAIL t5_head got v=%b d=%0d want 1/1", m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b1;
    send_beat(32'd114, 16'h0300, 1'b0);
    m_axis_tready = 1'b0;
    n_cmp++; if (o_level !== 7'd64 || o_overflow !== 1'b0) begin n_err++; $display("FAIL t5_accept got level=%0d ovf=%b want 64/0", o_level, o_overflow); end
    n_cmp++; if (q.size() !== 1 || q[0].data !== 32'd1) begin n_err++; $display("FAIL t5_popped got n=%0d d=%0d want 1/1", q.size(), q[0].data); end
    n_cmp++; if (m_axis_tdata !== 32'd2) begin n_err++; $display("FAIL t5_next_head got %0d want 2", m_axis_tdata); end
  endtask

  task automatic test_orphan_last();
    apply_reset();
    i_rlast = 1'b1;
    tick();
    i_rlast = 1'b0;
    n_cmp++; if (o_orphan_last !== 1'b1 || o_level !== 7'd0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL t4_orphan got orphan=%b level=%0d v=%b want 1/0/0", o_orphan_last, o_level, m_axis_tvalid); end
    i_rlast = 1'b1; i_clr_err = 1'b1;
    tick();
    i_rlast = 1'b0;
    n_cmp++; if (o_orphan_last !== 1'b1) begin n_err++; $display("FAIL t4_set_wins got %b want 1", o_orphan_last); end
    tick();
    i_clr_err = 1'b0;
    n_cmp++; if (o_orphan_last !== 1'b0 || o_overflow !== 1'b0) begin n_err++; $display("FAIL t4_clear got orphan=%b ovf=%b want 0/0", o_orphan_last, o_overflow); end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    for (int i = 1; i <= 11; i++) send_beat(32'h600 + i, 16'h0600, 1'b0);
    n_cmp++; if (o_level !== 7'd10) begin n_err++; $display("FAIL t6_level got %0d want 10", o_level); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (m_axis_tvalid !== 1'b0 || o_level !== 7'd0 || o_rready !== 1'b0) begin n_err++; $display("FAIL t6_in_reset got v=%b level=%0d rready=%b want 0/0/0", m_axis_tvalid, o_level, o_rready); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (o_rready !== 1'b1) begin n_err++; $display("FAIL t6_release got rready=%b want 1", o_rready); end
    i_rlast = 1'b1;
    tick();
    i_rlast = 1'b0;
    n_cmp++; if (o_orphan_last !== 1'b1 || o_level !== 7'd0) begin n_err++; $display("FAIL t6_stage_flushed got orphan=%b level=%0d want 1/0", o_orphan_last, o_level); end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_late_rlast();
    test_fill_overflow();
    test_full_push_pop();
    test_orphan_last();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
